// File: rtl/mem_pkg.sv
// mem_pkg: shared mem_rw encodings, RV32 load/store size codes and data_mem FSM states
package mem_pkg;
   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_LOAD  = 2'b01;
   localparam logic [1:0] MEM_STORE = 2'b10;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane enables, store lane placement, load extraction/extension and misalign detection
module lsu_align
   import mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] ldata,
   output logic        misalign
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b        = rword[{addr_lo, 3'b000} +: 8];
      h        = addr_lo[1] ? rword[31:16] : rword[15:0];
      be       = funct3[1:0] == 2'b00 ? 4'b0001 << addr_lo :
                 funct3[1:0] == 2'b01 ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      // replicating the data puts it in every lane; the enables pick the addressed one
      wword    = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                 funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
      ldata    = funct3 == F3_B  ? {{24{b[7]}}, b} :
                 funct3 == F3_H  ? {{16{h[15]}}, h} :
                 funct3 == F3_BU ? {24'b0, b} :
                 funct3 == F3_HU ? {16'b0, h} : rword;
      misalign = (funct3[1:0] == 2'b01 && addr_lo[0]) || (funct3 == F3_W && addr_lo != 2'b00);
   end
endmodule

// File: rtl/data_mem.sv
// data_mem: single-request load/store responder with programmable latency and error reporting
module data_mem
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  mem_rw,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] rdata,
   output logic        err
);
   localparam int AW = $clog2(DEPTH_WORDS);
   state_t      state;
   logic [3:0]  cnt;
   logic [1:0]  rw_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] mem [DEPTH_WORDS];
   logic [3:0]  be;
   logic [31:0] wword, ldata, rword;
   logic        misalign, is_ld, is_st, bad_f3, oor, fail, fire;
   assign rword     = mem[addr_q[AW+1:2]];
   assign req_ready = state == IDLE && !rst;
   lsu_align u_align (
      .funct3   (f3_q),
      .addr_lo  (addr_q[1:0]),
      .wdata    (wdata_q),
      .rword    (rword),
      .be       (be),
      .wword    (wword),
      .ldata    (ldata),
      .misalign (misalign)
   );
   always_comb begin
      is_ld  = rw_q == MEM_LOAD;
      is_st  = rw_q == MEM_STORE;
      bad_f3 = is_ld ? (f3_q == 3'b011 || f3_q[2:1] == 2'b11) : (f3_q > F3_W);
      oor    = addr_q[31:2] >= 30'(DEPTH_WORDS);
      fail   = !(is_ld || is_st) || bad_f3 || misalign || oor;
      fire   = state == WAIT && cnt == 4'd0 && !rst;
   end
   // storage has no reset; a reset at the commit edge suppresses the write via fire
   always_ff @(posedge clk)
      if (fire && is_st && !fail)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         resp_valid <= 1'b0;
         rdata      <= '0;
         err        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               rw_q    <= mem_rw;
               f3_q    <= funct3;
               addr_q  <= addr;
               wdata_q <= wdata;
               cnt     <= 4'(LATENCY - 1);
               state   <= WAIT;
            end
            WAIT: if (cnt == 4'd0) begin
               rdata      <= (is_ld && !fail) ? ldata : '0;
               err        <= fail;
               resp_valid <= 1'b1;
               state      <= RESP;
            end else cnt <= cnt - 4'd1;
            RESP: if (resp_ready) begin
               resp_valid <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/data_mem.md
# data_mem

Data-memory responder for the single-cycle RV32 core's load/store port. It accepts one request at a time over a valid/ready handshake, decodes RV32 byte, halfword and word access sizes, applies sign or zero extension on loads and byte-lane masking on stores, and returns a response after a programmable latency. The core's memory-read writeback path (`mem_out`) and the `mem_rw` control field come from this block. It will later sit in front of a cache or bus bridge without changing the core-side protocol.

## Interface
- `DEPTH_WORDS`, 1024: storage size in 32-bit words; power of two.
- `LATENCY`, 1: edges from request accept to response valid; legal range 1..15.

- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `mem_rw`  in  2  00 none, 01 load, 10 store, 11 reserved.
- `funct3`  in  3  RV32 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-aligned (byte/half in the low bits).
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  requester takes the response.
- `rdata`  out  32  load result, extended to 32 bits; 0 for stores and errors.
- `err`  out  1  qualifies `resp_valid`; 1 means the request was rejected.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, latch `mem_rw`, `funct3`, `addr` and `wdata`, load the counter with LATENCY-1, and go to WAIT.
- WAIT:
  - Decrement the counter.
  - When the counter reaches 0 (immediately if LATENCY=1), perform the access, register `rdata`/`err`, and go to RESP.
- RESP:
  - `resp_valid`=1; `rdata`/`err` are held stable.
  - On `resp_ready`, go to IDLE.
- Error conditions (set `err`=1, no storage modified, `rdata`=0):
  - `mem_rw` is 00 or 11.
  - Load with `funct3` in {011, 110, 111}.
  - Store with `funct3` not in {000, 001, 010}.
  - Misalignment: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
  - Out of range: `addr[31:2]` ≥ DEPTH_WORDS.
- Load extraction:
  - Select the byte lane with `addr[1:0]` and the halfword with `addr[1]`.
  - B and H sign-extend; BU and HU zero-extend.
- Store lane placement:
  - Byte enables are B: 1 lane, H: 2 lanes, W: 4 lanes.
  - `wdata` is shifted to the addressed lane.
  - Unselected bytes keep their old value.
- Storage contents are not cleared by reset; the initial contents are undefined.

## Timing
- While `rst`=1: `req_ready`=0, `resp_valid`=0, `rdata`=0, `err`=0, and state is IDLE. `req_ready`=1 in the first cycle after `rst` falls.
- Request accepted at edge E: `resp_valid`=1 after edge E+LATENCY.
- A store commits at edge E+LATENCY. A load accepted afterwards returns the new data.
- Response taken at edge R: `req_ready`=1 after R. A new request can therefore be accepted at R+1, which gives a minimum period of LATENCY+2 cycles per transaction.
- `req_ready`=0 in WAIT and RESP. `req_valid` is ignored there and nothing is queued.
- If `resp_ready` is held low, the response is held indefinitely with no change to `rdata`/`err`.
- Reset in WAIT or RESP: the transaction is dropped. A store not yet committed (reset at or before edge E+LATENCY) is not written.

## Structure
- Package `mem_pkg` holds:
  - `mem_rw` encodings (`MEM_NONE`, `MEM_LOAD`, `MEM_STORE`);
  - `funct3` size constants;
  - the FSM state enum.
  - The core's decoder imports the same `mem_rw` constants.
- Sub-module `lsu_align` (combinational) takes `funct3`, `addr[1:0]`, `wdata` and the raw word. It produces:
  - byte enables;
  - the shifted store word;
  - the extended load value;
  - the misalign flag.

## Test plan
- Store W 0xDEADBEEF to 0x10, then load W from 0x10 → `rdata`=0xDEADBEEF, `err`=0; with LATENCY=3, `resp_valid` rises 3 edges after accept.
- Store B 0x80 to 0x21, then load B/BU from 0x21 → 0xFFFFFF80 / 0x00000080; a load W from 0x20 shows only byte 1 changed.
- Store H 0x8001 to 0x32, then load H/HU from 0x32 → 0xFFFF8001 / 0x00008001.
- Load H at 0x33, load W at 0x22, and `addr`=4·DEPTH_WORDS → `err`=1, `rdata`=0; a following load W at the original word is unchanged.
- Hold `resp_ready`=0 for 5 cycles → `resp_valid` and `rdata` stay stable and `req_ready`=0; then raise `resp_ready` → `req_ready`=1 the next cycle.
- Assert `rst` one edge before a store commits (LATENCY=4) → no response; a later load W shows the old contents.
